reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 64, meaning architectural register data width.
REQ-002 Parameter NUM_REGS, default 32, meaning register count; power of two, at least 4; AW = log2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, meaning read port count, 1..4.
REQ-004 Parameter STORE_W, default 32, meaning stored bits per register; STORE_W <= DATA_W; read data is zero-extended to DATA_W.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rd_addr  input  NUM_RD*AW  packed read addresses; port p uses bits [p*AW +: AW].
REQ-008 rd_en  input  NUM_RD  per-port read enable.
REQ-009 rd_data  output  NUM_RD*DATA_W  packed registered read data; port p uses bits [p*DATA_W +: DATA_W].
REQ-010 wr_en  input  1  writeback enable.
REQ-011 wr_addr  input  AW  writeback destination.
REQ-012 wr_link  input  1  jump-and-link writeback; forces destination NUM_REGS-1.
REQ-013 wr_data  input  DATA_W  writeback data; only bits [STORE_W-1:0] are stored.
REQ-014 iss_en  input  1  instruction issue; marks iss_addr pending.
REQ-015 iss_addr  input  AW  destination of the issuing instruction.
REQ-016 stall  output  1  combinational hazard flag for the current reads.
REQ-017 pend  output  NUM_REGS  registered pending bit per register.

Function
REQ-018 Effective write address = NUM_REGS-1 when wr_link=1, else wr_addr; the write occurs when wr_en=1 and the effective address is not 0.
REQ-019 Writes commit on the rising edge; the write is suppressed when wr_en=0, or when wr_link=0 and wr_addr=0.
REQ-020 Register 0 always reads as zero; no write or issue changes its contents or pend[0].
REQ-021 Read latency is 1 cycle: on the rising edge with rd_en[p]=1, rd_data port p loads the zero-extended contents of rd_addr port p; with rd_en[p]=0 it holds its value.
REQ-022 Write-through bypass: when a same-edge write targets a read address, rd_data returns the new wr_data[STORE_W-1:0] zero-extended, not the old value.
REQ-023 Address 0 reads return 0 even when a write or bypass targets address 0.
REQ-024 Scoreboard: on the rising edge with iss_en=1 and iss_addr not 0, pend[iss_addr] is set.
REQ-025 A committed write clears pend at the effective write address.
REQ-026 When an issue and a write hit the same register on the same edge, the issue wins and pend is set.
REQ-027 stall = 1 when any port p with rd_en[p]=1 has pend[rd_addr_p]=1, unless a write to that address commits this cycle; address 0 never stalls.
REQ-028 stall does not gate reads; rd_data updates on every enabled read regardless of stall.
REQ-029 Ports are independent; any number of ports may read the same address in the same cycle.

Reset
REQ-030 While rst=1, register i holds i, zero-extended and truncated to STORE_W bits, so register 0 holds 0.
REQ-031 While rst=1, all pend bits are 0 and all rd_data ports are 0.
REQ-032 Reset asserted mid-operation overrides any same-cycle write, issue or read.
REQ-033 After rst deasserts, the first rising edge behaves normally.

Verification
REQ-034 Reset check: assert rst, release it, read r5 and r31 -> rd_data = 5 and 31 one cycle later, and pend = 0.
REQ-035 Bypass and zero-extension: write r7 = 64'hFFFF_FFFF_1234_5678 while reading r7 on port 1 on the same edge -> port 1 = 64'h0000_0000_1234_5678 next cycle; a later read also returns this value.
REQ-036 Link write: wr_en=1, wr_link=1, wr_addr=3, data 0x40 -> r31 = 0x40 and r3 unchanged (3).
REQ-037 r0 protection: write 0xAB to r0 and issue r0 -> r0 reads 0, pend[0]=0, stall=0.
REQ-038 Scoreboard: issue r9, then read r9 -> stall=1; write r9 = 0x11 while reading r9 -> stall=0, pend[9] clears and rd_data = 0x11; same-edge issue and write of r9 -> pend[9]=1.
REQ-039 Reset mid-operation: assert rst on the same edge as a write of r4 = 0x99 -> r4 = 4 and pend = 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file (rd_addr/rd_en -> registered rd_data, wr_* writeback with link and bypass, iss_* scoreboard -> pend/stall)
module reg_file_mp #(
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int STORE_W = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic                     wr_link,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      pend
);
  logic [STORE_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rdq [NUM_RD];
  logic [DATA_W-1:0] rv [NUM_RD];
  logic [NUM_RD-1:0] hz;
  logic [AW-1:0] wa;
  logic we;
  logic [NUM_REGS-1:0] clr, set;
  logic unused;
  assign unused = ^wr_data;
  assign wa = wr_link ? AW'(NUM_REGS - 1) : wr_addr;
  assign we = wr_en && wa != '0;
  assign clr = we ? NUM_REGS'(1) << wa : '0;
  assign set = (iss_en && iss_addr != '0) ? NUM_REGS'(1) << iss_addr : '0;
  genvar g;
  for (g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[g*AW +: AW];
    assign rv[g] = (a == '0) ? '0 : DATA_W'((we && wa == a) ? wr_data[STORE_W-1:0] : regs[a]);
    assign hz[g] = rd_en[g] && a != '0 && pend[a] && !(we && wa == a);
    assign rd_data[g*DATA_W +: DATA_W] = rdq[g];
  end
  assign stall = |hz;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= STORE_W'(i);
      for (int p = 0; p < NUM_RD; p++) rdq[p] <= '0;
      pend <= '0;
    end else begin
      if (we) regs[wa] <= wr_data[STORE_W-1:0];
      for (int p = 0; p < NUM_RD; p++) if (rd_en[p]) rdq[p] <= rv[p];
      pend <= (pend & ~clr) | set;
    end
endmodule
